// File: rtl/fft_addr_sched_if.sv
// fft_addr_sched_if
//   Butterfly address bus between the FFT address scheduler and the
//   butterfly datapath.
//   master (scheduler): drives out_valid, addr_a, addr_b, tw_addr, stage,
//                       last_in_stage; receives out_ready.
//   slave  (datapath) : the mirror image.
//   N_LOG2        : log2 of the FFT size, sets the data address width.
//   TW_ADDR_WIDTH : twiddle ROM address width.
interface fft_addr_sched_if #(
    parameter int N_LOG2        = 10,
    parameter int TW_ADDR_WIDTH = 10
);
    logic                     out_valid;
    logic                     out_ready;
    logic [N_LOG2-1:0]        addr_a;
    logic [N_LOG2-1:0]        addr_b;
    logic [TW_ADDR_WIDTH-1:0] tw_addr;
    logic [3:0]               stage;
    logic                     last_in_stage;

    modport master (
        output out_valid, addr_a, addr_b, tw_addr, stage, last_in_stage,
        input  out_ready
    );

    modport slave (
        input  out_valid, addr_a, addr_b, tw_addr, stage, last_in_stage,
        output out_ready
    );
endinterface

// File: rtl/fft_addr_sched.sv
// fft_addr_sched
//   Address sequencer for an in-place radix-2 DIT FFT. Walks every stage and
//   butterfly, presenting data-RAM addresses (a, b) and the twiddle ROM index
//   for each butterfly on a valid/ready bus. Optional idle gap between stages
//   lets the butterfly pipeline drain.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : begin a transform (only honoured in IDLE)
//   busy   : high while stages are being walked (RUN and GAP)
//   done   : one-cycle pulse after the final butterfly fires
//   bus    : master side of fft_addr_sched_if (addresses, stage, last flag,
//            out_valid/out_ready handshake)
module fft_addr_sched #(
    parameter int N_LOG2        = 10,
    parameter int TW_ADDR_WIDTH = 10,
    parameter int STAGE_GAP     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    fft_addr_sched_if.master   bus
);
    localparam int BF_W  = N_LOG2 - 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               stage_q, stage_d;
    logic [BF_W-1:0]          bf_q, bf_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [N_LOG2-1:0]        addr_a_q, addr_a_d;
    logic [N_LOG2-1:0]        addr_b_q, addr_b_d;
    logic [TW_ADDR_WIDTH-1:0] tw_q, tw_d;

    logic                     fire;
    logic [N_LOG2-1:0]        bf_ext, half, j_n, g_n;
    logic [3:0]               tw_sh;

    assign fire = valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bf_d    = bf_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    bf_d    = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (fire) begin
                    if (&bf_q) begin
                        if (stage_q == 4'(N_LOG2 - 1)) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (STAGE_GAP == 0) begin
                            // back-to-back stages, no bubble
                            stage_d = stage_q + 4'd1;
                            bf_d    = '0;
                        end else begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            gap_d   = '0;
                        end
                    end else begin
                        bf_d = bf_q + BF_W'(1);
                    end
                end
            end
            GAP: begin
                // gap_q counts 0..STAGE_GAP-1, giving exactly STAGE_GAP idle cycles
                if (32'(gap_q) == STAGE_GAP - 1) begin
                    state_d = RUN;
                    stage_d = stage_q + 4'd1;
                    bf_d    = '0;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next (stage, bf) so they land in
        // registers; with bf/stage held during a stall they stay stable.
        bf_ext   = N_LOG2'(bf_d);
        half     = N_LOG2'(1) << stage_d;
        j_n      = bf_ext & (half - N_LOG2'(1));
        g_n      = bf_ext >> stage_d;
        addr_a_d = (g_n << (stage_d + 4'd1)) | j_n;
        addr_b_d = addr_a_d | half;
        tw_sh    = 4'(N_LOG2 - 1) - stage_d;
        tw_d     = TW_ADDR_WIDTH'(j_n << tw_sh);
        last_d   = valid_d & (&bf_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            bf_q     <= '0;
            gap_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            bf_q     <= bf_d;
            gap_q    <= gap_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.addr_a        = addr_a_q;
    assign bus.addr_b        = addr_b_q;
    assign bus.tw_addr       = tw_q;
    assign bus.stage         = stage_q;
    assign bus.last_in_stage = last_q;
    assign busy              = busy_q;
    assign done              = done_q;
endmodule

// File: tb/tb_fft_addr_sched.sv
// tb_fft_addr_sched
//   Directed bench for fft_addr_sched. Three instances:
//     u3  : N_LOG2=3,  STAGE_GAP=0 (full sequence, stall, ignored start)
//     u3g : N_LOG2=3,  STAGE_GAP=2 (stage gap timing)
//     u10 : N_LOG2=10, STAGE_GAP=4 (default size, mid-run reset)
module tb_fft_addr_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pk(input int a, input int b, input int t);
        return (a << 20) | (b << 10) | t;
    endfunction

    // hand-computed sequence for N=8
    int exp_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    logic rst3, start3, busy3, done3;
    logic rstg, startg, busyg, doneg;
    logic rst10, start10, busy10, done10;

    fft_addr_sched_if #(.N_LOG2(3),  .TW_ADDR_WIDTH(4))  b3 ();
    fft_addr_sched_if #(.N_LOG2(3),  .TW_ADDR_WIDTH(4))  bg ();
    fft_addr_sched_if #(.N_LOG2(10), .TW_ADDR_WIDTH(10)) b10 ();

    fft_addr_sched #(.N_LOG2(3), .TW_ADDR_WIDTH(4), .STAGE_GAP(0)) u3 (
        .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3), .bus(b3));
    fft_addr_sched #(.N_LOG2(3), .TW_ADDR_WIDTH(4), .STAGE_GAP(2)) u3g (
        .clk(clk), .rst(rstg), .start(startg), .busy(busyg), .done(doneg), .bus(bg));
    fft_addr_sched #(.N_LOG2(10), .TW_ADDR_WIDTH(10), .STAGE_GAP(4)) u10 (
        .clk(clk), .rst(rst10), .start(start10), .busy(busy10), .done(done10), .bus(b10));

    function automatic int cur3();
        return pk(int'(b3.addr_a), int'(b3.addr_b), int'(b3.tw_addr));
    endfunction
    function automatic int cur10();
        return pk(int'(b10.addr_a), int'(b10.addr_b), int'(b10.tw_addr));
    endfunction

    // One N=8 transform on u3; optional 3-cycle stall on fire stall_at and
    // optional stray start pulses in RUN and in the DONE cycle.
    task automatic run3(input int stall_at, input bit poke, input string tag);
        int cyc, nf, ndone, nst;
        b3.out_ready = 1'b1;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        cyc = 1; nf = 0; ndone = 0; nst = 0;
        while (nf < 12 && cyc < 80) begin
            start3 = poke && (cyc == 5);
            if (done3) ndone++;
            chk({tag, "_busy"}, int'(busy3), 1);
            if (b3.out_valid) begin
                if (nf == stall_at && nst < 3) begin
                    b3.out_ready = 1'b0;
                    nst++;
                    chk({tag, "_stall_hold"}, cur3(), pk(exp_a[nf], exp_b[nf], exp_t[nf]));
                end else begin
                    b3.out_ready = 1'b1;
                    chk({tag, "_abt"}, cur3(), pk(exp_a[nf], exp_b[nf], exp_t[nf]));
                    chk({tag, "_last"}, int'(b3.last_in_stage), int'(nf % 4 == 3));
                    nf++;
                end
            end
            step();
            cyc++;
        end
        start3 = 1'b0;
        b3.out_ready = 1'b1;
        chk({tag, "_fires"}, nf, 12);
        chk({tag, "_lat"}, cyc, 13 + nst);
        chk({tag, "_done"}, int'(done3), 1);
        chk({tag, "_busy_fall"}, int'(busy3), 0);
        chk({tag, "_valid_done"}, int'(b3.out_valid), 0);
        chk({tag, "_early_done"}, ndone, 0);
        start3 = poke;
        step();
        start3 = 1'b0;
        chk({tag, "_done_pulse"}, int'(done3), 0);
        repeat (3) step();
        chk({tag, "_idle_valid"}, int'(b3.out_valid), 0);
        chk({tag, "_idle_busy"}, int'(busy3), 0);
    endtask

    initial begin
        int cyc, nf, gap0, gap1, stray, twbad, ndone;
        rst3 = 1'b1; rstg = 1'b1; rst10 = 1'b1;
        start3 = 1'b0; startg = 1'b0; start10 = 1'b0;
        b3.out_ready = 1'b1; bg.out_ready = 1'b1; b10.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", int'(b3.out_valid), 0);
        chk("rst_busy", int'(busy3), 0);
        chk("rst_done", int'(done3), 0);
        chk("rst_abt", cur3(), 0);
        chk("rst_stage", int'(b3.stage), 0);
        chk("rst_last", int'(b3.last_in_stage), 0);
        chk("rst10_abt", cur10(), 0);
        rst3 = 1'b0; rstg = 1'b0; rst10 = 1'b0;
        step();

        // full sequence, stall, ignored starts
        run3(99, 1'b0, "seq");
        run3(5, 1'b0, "stall");
        run3(99, 1'b1, "ignstart");

        // stage gap
        startg = 1'b1;
        step();
        startg = 1'b0;
        cyc = 1; nf = 0; gap0 = 0; gap1 = 0; stray = 0;
        while (!doneg && cyc < 80) begin
            if (bg.out_valid) begin
                chk("gap_abt", pk(int'(bg.addr_a), int'(bg.addr_b), int'(bg.tw_addr)),
                    pk(exp_a[nf % 12], exp_b[nf % 12], exp_t[nf % 12]));
                nf++;
            end else if (nf == 4) gap0++;
            else if (nf == 8) gap1++;
            else stray++;
            step();
            cyc++;
        end
        chk("gap_after_s0", gap0, 2);
        chk("gap_after_s1", gap1, 2);
        chk("gap_stray", stray, 0);
        chk("gap_fires", nf, 12);
        chk("gap_lat", cyc, 17);

        // default size, full transform
        start10 = 1'b1;
        step();
        start10 = 1'b0;
        cyc = 1; nf = 0; twbad = 0;
        while (!done10 && cyc < 6000) begin
            if (b10.out_valid) begin
                if (b10.stage == 4'd0 && b10.tw_addr != '0) twbad++;
                if (nf == 2148) begin
                    chk("n10_s4bf100", cur10(), pk(196, 212, 128));
                    chk("n10_s4_stage", int'(b10.stage), 4);
                end
                if (nf == 5119) begin
                    chk("n10_s9bf511", cur10(), pk(511, 1023, 511));
                    chk("n10_s9_stage", int'(b10.stage), 9);
                    chk("n10_s9_last", int'(b10.last_in_stage), 1);
                end
                nf++;
            end
            step();
            cyc++;
        end
        chk("n10_fires", nf, 5120);
        chk("n10_tw_s0", twbad, 0);
        chk("n10_lat", cyc, 5157);
        step();
        step();

        // mid-run reset at stage 4, bf 100
        start10 = 1'b1;
        step();
        start10 = 1'b0;
        cyc = 0; nf = 0;
        while (nf < 2148 && cyc < 3000) begin
            if (b10.out_valid) nf++;
            step();
            cyc++;
        end
        chk("mrst_pre_abt", cur10(), pk(196, 212, 128));
        chk("mrst_pre_stage", int'(b10.stage), 4);
        rst10 = 1'b1;
        step();
        rst10 = 1'b0;
        chk("mrst_valid", int'(b10.out_valid), 0);
        chk("mrst_busy", int'(busy10), 0);
        chk("mrst_stage", int'(b10.stage), 0);
        chk("mrst_done", int'(done10), 0);
        chk("mrst_abt", cur10(), 0);
        ndone = 0;
        repeat (4) begin
            step();
            if (done10) ndone++;
        end
        chk("mrst_no_done", ndone, 0);
        start10 = 1'b1;
        step();
        start10 = 1'b0;
        chk("mrst_restart_valid", int'(b10.out_valid), 1);
        chk("mrst_restart_abt", cur10(), pk(0, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fft_addr_sched.md
Name: fft_addr_sched

Overview:
- Sequencer for an in-place radix-2 DIT FFT: walks every stage and butterfly and emits data-RAM addresses (a, b) plus the twiddle ROM address for each butterfly.
- Sits between the FFT top-level control and the butterfly datapath.
- tw_addr drives the Q1.15 twiddle ROM addr port directly; the ROM is combinational, so twiddles appear in the same cycle as the addresses.

Parameters:
- N_LOG2, 10, log2 of FFT size N (N = 2^N_LOG2, legal range 2..10).
- TW_ADDR_WIDTH, 10, twiddle ROM address width; must be >= N_LOG2-1.
- STAGE_GAP, 4, idle cycles inserted between stages so the butterfly pipeline drains (0 = no gap).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a transform; sampled only in IDLE
- out_valid  out  1  a butterfly address set is present
- out_ready  in  1  downstream accepts the current set; fire = out_valid & out_ready
- addr_a  out  N_LOG2  upper butterfly input/output index
- addr_b  out  N_LOG2  lower butterfly index (addr_a + half)
- tw_addr  out  TW_ADDR_WIDTH  twiddle index k, zero-extended
- stage  out  4  current stage, 0..N_LOG2-1
- last_in_stage  out  1  high with the final butterfly of the current stage
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final butterfly fires

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - out_valid, busy, done, last_in_stage = 0.
  - addr_a, addr_b, tw_addr, stage = 0.
  - Internal counters = 0.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 -> RUN next cycle, with stage = 0 and butterfly counter bf = 0.
  - out_valid rises in the first RUN cycle (1-cycle start latency).
- RUN:
  - out_valid = 1.
  - Outputs are registered and derived from (stage s, bf):
    - half = 2^s
    - j = bf & (half-1)
    - g = bf >> s
    - addr_a = (g << (s+1)) | j
    - addr_b = addr_a | half
    - tw_addr = j << (N_LOG2-1-s)
  - bf counts 0..N/2-1 per stage. It advances only on fire.
  - While out_valid=1 and out_ready=0, every output holds stable.
  - last_in_stage = (bf == N/2-1).
- End of stage: fire with last_in_stage=1.
  - If s == N_LOG2-1 -> DONE.
  - Else if STAGE_GAP == 0 -> stay in RUN with s+1, bf = 0 next cycle (no bubble).
  - Else -> GAP.
- GAP:
  - out_valid = 0.
  - Counter runs for exactly STAGE_GAP cycles, then -> RUN with s+1, bf = 0.
- DONE:
  - done = 1, busy = 0 and out_valid = 0 for one cycle, then -> IDLE.
- busy = 1 in RUN and GAP, 0 otherwise.
- start while not in IDLE is ignored (no queuing). start in the DONE cycle is also ignored.
- out_ready is don't-care when out_valid = 0.
- rst mid-transform: next cycle is IDLE with all outputs at reset values. No done pulse.
- Total fires per transform = (N/2)·N_LOG2.
- Minimum cycles from start to done with out_ready tied high = 1 + (N/2)·N_LOG2 + (N_LOG2-1)·STAGE_GAP.
- Width rules:
  - All address arithmetic is unsigned.
  - tw_addr uses N_LOG2-1 significant bits. Upper bits are 0.
  - No wrap: bf never exceeds N/2-1.

Test Plan:
- Full sequence: N_LOG2=3, STAGE_GAP=0, out_ready=1, start pulse. Requires these (a,b,tw) in order:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - done pulses exactly 1 cycle after the 12th fire, and busy falls with it.
- Stall: as above, but out_ready=0 for 3 cycles while (1,3,2) is presented. Requires:
  - outputs stable and out_valid=1 for those cycles;
  - the sequence then resumes unchanged;
  - total 12 fires.
- Stage gap: N_LOG2=3, STAGE_GAP=2. Requires:
  - exactly 2 cycles with out_valid=0 after each last_in_stage fire of stages 0 and 1;
  - start-to-done = 17 cycles.
- Mid-run reset: N_LOG2=10, assert rst during stage 4, bf=100. Requires:
  - next cycle out_valid=0, busy=0, stage=0, no done pulse;
  - a new start replays from (0,1,0).
- Ignored start: pulse start during RUN and again in the DONE cycle. Requires the sequence and fire count to be unchanged, with no second transform started.
- Default size: N_LOG2=10. Requires:
  - 5120 fires;
  - stage 9 bf=511 gives (511,1023,511);
  - stage 0 tw_addr always 0.
